// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment scan driver.
//   SEG_BLANK : all segments off (active-low bus, {g,f,e,d,c,b,a})
//   SEG_LUT   : hex nibble -> active-low segment pattern
// ----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Index = nibble value; bit order {g,f,e,d,c,b,a}, 0 = segment on.
   localparam logic [6:0] SEG_LUT [0:15] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver_if
// Host-side and pin-side signals of the scan driver.
//   value/load/dp          : display contents, captured into pending on load
//   digit_en/blink_mask/lz : live display controls
//   seg_n/dp_n/an_n        : active-low board pins
//   frame_tick             : one-cycle pulse at scan wrap to digit 0
// master = display logic (drives contents, observes pins), slave = driver.
// ----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
   parameter int DIGITS = 8
);
   logic [4*DIGITS-1:0] value;
   logic                load;
   logic [DIGITS-1:0]   dp;
   logic [DIGITS-1:0]   digit_en;
   logic [DIGITS-1:0]   blink_mask;
   logic                lz_suppress;
   logic [6:0]          seg_n;
   logic                dp_n;
   logic [DIGITS-1:0]   an_n;
   logic                frame_tick;

   modport master (
      output value, load, dp, digit_en, blink_mask, lz_suppress,
      input  seg_n, dp_n, an_n, frame_tick
   );

   modport slave (
      input  value, load, dp, digit_en, blink_mask, lz_suppress,
      output seg_n, dp_n, an_n, frame_tick
   );
endinterface

// File: rtl/seg7_hex_rom.sv
// ----------------------------------------------------------------------------
// seg7_hex_rom
// Combinational hex nibble to active-low seven-segment lookup.
//   nibble : 4-bit hex value
//   seg_n  : {g,f,e,d,c,b,a}, 0 = segment on
// ----------------------------------------------------------------------------
module seg7_hex_rom
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = SEG_LUT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for DIGITS common-anode seven-segment digits on a
// shared segment bus. One slot of SCAN_DIV cycles per digit, the first
// BLANK_CYCLES of each slot with all anodes off to avoid ghosting.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of seg7_scan_driver_if (contents in, pins out)
// Display contents are double-buffered (pending -> active at the frame wrap)
// so a frame never shows a mix of old and new values.
// ----------------------------------------------------------------------------
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 2,
   parameter int BLINK_FRAMES = 64
) (
   input  logic              clk,
   input  logic              rst,
   seg7_scan_driver_if.slave bus
);

   localparam int SLOT_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
   localparam int IDX_W  = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
   localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
   localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

   typedef logic [DIGITS-1:0][3:0] nib_vec_t;

   // scan / blink state
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [FRM_W-1:0]  frm_q, frm_d;
   logic              phase_q, phase_d;
   // display contents
   nib_vec_t          pend_val_q, pend_val_d;
   logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
   nib_vec_t          act_val_q, act_val_d;
   logic [DIGITS-1:0] act_dp_q, act_dp_d;
   // registered pins
   logic [6:0]        seg_q, seg_d;
   logic              dpn_q, dpn_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic              tick_q, tick_d;

   logic              wrap_slot, wrap_frame, in_blank, show;
   logic [DIGITS-1:0] lz_sup, lit;
   logic [3:0]        cur_nib;
   logic [6:0]        cur_seg;

   assign wrap_slot  = (slot_q == SLOT_LAST);
   assign wrap_frame = wrap_slot && (idx_q == IDX_LAST);
   assign in_blank   = (32'(slot_q) < BLANK_CYCLES);
   assign cur_nib    = act_val_q[idx_q];

   seg7_hex_rom u_rom (
      .nibble (cur_nib),
      .seg_n  (cur_seg)
   );

   // Scan counters, content buffers and blink phase.
   always_comb begin
      slot_d     = wrap_slot ? '0 : slot_q + 1'b1;
      idx_d      = idx_q;
      frm_d      = frm_q;
      phase_d    = phase_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      act_val_d  = act_val_q;
      act_dp_d   = act_dp_q;
      tick_d     = wrap_frame;

      if (wrap_slot)
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      if (bus.load) begin
         pend_val_d = bus.value;
         pend_dp_d  = bus.dp;
      end

      if (wrap_frame) begin
         // pend_*_d already folds in a same-cycle load, so a load on the
         // frame boundary goes straight to the display.
         act_val_d = pend_val_d;
         act_dp_d  = pend_dp_d;
         if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end
   end

   // Leading-zero suppression: walk down from the top digit while the run
   // of zero nibbles is unbroken. Digit 0 always shows.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      lz_sup   = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run  = zero_run & (act_val_q[i] == 4'h0);
         lz_sup[i] = bus.lz_suppress & zero_run & (i != 0);
      end
   end

   assign lit = bus.digit_en & ~lz_sup & ~(bus.blink_mask & {DIGITS{phase_q}});

   // Pin values for the current counter state, registered below.
   always_comb begin
      show  = !in_blank && lit[idx_q];
      an_d  = '1;
      seg_d = SEG_BLANK;
      dpn_d = 1'b1;
      if (show) begin
         an_d  = ~(DIGITS'(1) << idx_q);
         seg_d = cur_seg;
         dpn_d = ~act_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q     <= '0;
         idx_q      <= '0;
         frm_q      <= '0;
         phase_q    <= 1'b0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         act_val_q  <= '0;
         act_dp_q   <= '0;
         seg_q      <= SEG_BLANK;
         dpn_q      <= 1'b1;
         an_q       <= '1;
         tick_q     <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         idx_q      <= idx_d;
         frm_q      <= frm_d;
         phase_q    <= phase_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         act_val_q  <= act_val_d;
         act_dp_q   <= act_dp_d;
         seg_q      <= seg_d;
         dpn_q      <= dpn_d;
         an_q       <= an_d;
         tick_q     <= tick_d;
      end
   end

   assign bus.seg_n      = seg_q;
   assign bus.dp_n       = dpn_q;
   assign bus.an_n       = an_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4,
// BLANK_CYCLES=1, BLINK_FRAMES=2. A table of display settings with expected
// per-digit pin values, plus hand-written sequences for reset, tearing,
// frame-boundary load and blink.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

   localparam int D = 4;

   // expected active-low patterns, {g,f,e,d,c,b,a}
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SE = 7'b0000110;
   localparam logic [6:0] SF = 7'b0001110;
   localparam logic [6:0] BL = 7'h7F;
   localparam logic [3:0] AOFF = 4'b1111;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg7_scan_driver_if #(.DIGITS(D)) bus ();

   seg7_scan_driver #(
      .DIGITS(D), .SCAN_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic        lz;
      int          digit;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dpn;
   } vec_t;

   vec_t vecs[20];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_out(input string nm, input logic [3:0] an,
                          input logic [6:0] seg, input logic dpn);
      n_vec++;
      if (bus.an_n !== an || bus.seg_n !== seg || bus.dp_n !== dpn) begin
         n_bad++;
         $display("FAIL %s: got an_n=%b seg_n=%b dp_n=%b, want an_n=%b seg_n=%b dp_n=%b",
                  nm, bus.an_n, bus.seg_n, bus.dp_n, an, seg, dpn);
      end
   endtask

   task automatic chk_tick(input string nm, input logic exp);
      n_vec++;
      if (bus.frame_tick !== exp) begin
         n_bad++;
         $display("FAIL %s: got frame_tick=%b, want %b", nm, bus.frame_tick, exp);
      end
   endtask

   // Returns at the negedge of the first cycle with frame_tick high.
   task automatic wait_tick(input string nm);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = bus.frame_tick;
      end
      if (!got) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: no frame_tick within 64 cycles", nm);
      end
   endtask

   // Outputs lag the counters by one cycle: relative to the tick cycle,
   // digit d is blank at +4d+1 and lit at +4d+2..+4d+4.
   task automatic check_digit(input string nm, input int d, input logic [3:0] an,
                              input logic [6:0] seg, input logic dpn);
      wait_tick(nm);
      step(4 * d + 1);
      chk_out({nm, "_blank"}, AOFF, BL, 1'b1);
      step(1);
      chk_out({nm, "_first"}, an, seg, dpn);
      step(2);
      chk_out({nm, "_last"}, an, seg, dpn);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      bus.value = v;
      bus.dp    = d;
      bus.load  = 1'b1;
      step(1);
      bus.load  = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{16'h12AF, 4'h0, 4'hF, 1'b0, 3, 4'b0111, S1, 1'b1};
      vecs[1]  = '{16'h12AF, 4'h0, 4'hF, 1'b0, 2, 4'b1011, S2, 1'b1};
      vecs[2]  = '{16'h12AF, 4'h0, 4'hF, 1'b0, 1, 4'b1101, SA, 1'b1};
      vecs[3]  = '{16'h12AF, 4'h0, 4'hF, 1'b0, 0, 4'b1110, SF, 1'b1};
      vecs[4]  = '{16'h00E0, 4'h0, 4'hF, 1'b1, 3, AOFF,    BL, 1'b1};
      vecs[5]  = '{16'h00E0, 4'h0, 4'hF, 1'b1, 2, AOFF,    BL, 1'b1};
      vecs[6]  = '{16'h00E0, 4'h0, 4'hF, 1'b1, 1, 4'b1101, SE, 1'b1};
      vecs[7]  = '{16'h00E0, 4'h0, 4'hF, 1'b1, 0, 4'b1110, S0, 1'b1};
      vecs[8]  = '{16'h0000, 4'h0, 4'hF, 1'b1, 1, AOFF,    BL, 1'b1};
      vecs[9]  = '{16'h0000, 4'h0, 4'hF, 1'b1, 0, 4'b1110, S0, 1'b1};
      vecs[10] = '{16'h0000, 4'h0, 4'hF, 1'b0, 2, 4'b1011, S0, 1'b1};
      vecs[11] = '{16'h1234, 4'h4, 4'hF, 1'b0, 2, 4'b1011, S2, 1'b0};
      vecs[12] = '{16'h1234, 4'h4, 4'hF, 1'b0, 1, 4'b1101, S3, 1'b1};
      vecs[13] = '{16'h1234, 4'h4, 4'hB, 1'b0, 2, AOFF,    BL, 1'b1};
      vecs[14] = '{16'h0800, 4'h8, 4'hF, 1'b1, 3, AOFF,    BL, 1'b1};
      vecs[15] = '{16'h0800, 4'h8, 4'hF, 1'b1, 2, 4'b1011, S8, 1'b1};
      vecs[16] = '{16'h0800, 4'h8, 4'hF, 1'b1, 1, 4'b1101, S0, 1'b1};
      vecs[17] = '{16'h0050, 4'h0, 4'hF, 1'b1, 0, 4'b1110, S0, 1'b1};
      vecs[18] = '{16'h0050, 4'h0, 4'hF, 1'b1, 1, 4'b1101, S5, 1'b1};
      vecs[19] = '{16'h1234, 4'h0, 4'hF, 1'b1, 3, 4'b0111, S1, 1'b1};

      bus.value       = '0;
      bus.load        = 1'b0;
      bus.dp          = '0;
      bus.digit_en    = 4'hF;
      bus.blink_mask  = '0;
      bus.lz_suppress = 1'b0;

      // ---- reset state and scan start-up timing ----
      step(2);
      chk_out("rst_hold", AOFF, BL, 1'b1);
      chk_tick("rst_hold_tick", 1'b0);
      rst = 1'b0;
      chk_out("rel_c0", AOFF, BL, 1'b1);
      step(1);
      chk_out("rel_c1_blank", AOFF, BL, 1'b1);
      step(1);
      chk_out("rel_c2_d0", 4'b1110, S0, 1'b1);
      step(13);
      chk_tick("rel_c15_tick", 1'b0);
      step(1);
      chk_tick("rel_c16_tick", 1'b1);

      // ---- table of settings ----
      foreach (vecs[i]) begin
         bus.digit_en    = vecs[i].en;
         bus.lz_suppress = vecs[i].lz;
         do_load(vecs[i].value, vecs[i].dp);
         check_digit($sformatf("vec%0d", i), vecs[i].digit,
                     vecs[i].an, vecs[i].seg, vecs[i].dpn);
      end

      // ---- mid-frame load must not tear; boundary load shows at once ----
      bus.digit_en    = 4'hF;
      bus.lz_suppress = 1'b0;
      do_load(16'h1111, 4'h0);
      wait_tick("tear_t0");               // frame T shows 1111
      step(5);
      do_load(16'h2222, 4'h0);            // captured in digit 1's slot
      step(8);                            // T+14
      chk_out("tear_d3_old", 4'b0111, S1, 1'b1);
      step(2);                            // T+16
      chk_tick("tear_next_tick", 1'b1);
      step(2);                            // T+18
      chk_out("tear_d0_new", 4'b1110, S2, 1'b1);
      step(12);                           // T+30
      chk_out("bnd_d3_before", 4'b0111, S2, 1'b1);
      step(1);                            // T+31, last cycle of frame
      bus.value = 16'h3333;
      bus.load  = 1'b1;
      step(1);                            // T+32
      bus.load  = 1'b0;
      chk_tick("bnd_tick", 1'b1);
      step(2);
      chk_out("bnd_d0_direct", 4'b1110, S3, 1'b1);

      // ---- blink: digit 0 lit 2 frames, dark 2 frames ----
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      bus.blink_mask = 4'b0001;
      do_load(16'h1234, 4'h0);
      for (int k = 1; k <= 6; k++) begin
         wait_tick($sformatf("blink_f%0d", k));
         step(2);
         if (((k / 2) % 2) == 0)
            chk_out($sformatf("blink_f%0d_d0", k), 4'b1110, S4, 1'b1);
         else
            chk_out($sformatf("blink_f%0d_d0", k), AOFF, BL, 1'b1);
         step(4);
         chk_out($sformatf("blink_f%0d_d1", k), 4'b1101, S3, 1'b1);
      end
      bus.blink_mask = '0;

      // ---- reset in digit 2's slot ----
      do_load(16'h1234, 4'h0);
      wait_tick("mrst_t0");
      wait_tick("mrst_t1");
      step(10);
      chk_out("mrst_pre_d2", 4'b1011, S2, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk_out("mrst_async", AOFF, BL, 1'b1);
      chk_tick("mrst_async_tick", 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(2);
      chk_out("mrst_restart_d0", 4'b1110, S0, 1'b1);
      wait_tick("mrst_t2");
      step(2);
      chk_out("mrst_pending_lost", 4'b1110, S0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
